cliff_track: RTL and testbench

- Upstream stage of the mario sprite block. Generates the scrolling ground track: up to two cliff gaps that move right-to-left across the 640-px screen.
- Computes `mario_on_ground` from Mario's current x position and drives the game-level `game_over` flag that the mario block consumes.
- Also exports cliff geometry for the renderer and a distance score.

---
 rtl/cliff_track.sv | 164 ++++++++++++++++
 tb/tb_cliff_track.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cliff_track.sv
// Scrolling ground track for the mario block: up to two cliff gaps moving right-to-left,
// ground/fall detection against Mario's position, renderer geometry and a distance score.
module cliff_track #(
  parameter int          SCROLL_DIV = 200000,
  parameter int          SPAWN_X    = 640,
  parameter int          SPACE_MIN  = 160,
  parameter int          W_MIN      = 24,
  parameter int          MARIO_HALF = 16,
  parameter int          FLOOR_Y    = 480,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  output logic               mario_on_ground,
  output logic               game_over,
  output logic               running,
  output logic               cliff0_valid,
  output logic               cliff1_valid,
  output logic signed [10:0] cliff0_x,
  output logic signed [10:0] cliff1_x,
  output logic [5:0]         cliff0_w,
  output logic [5:0]         cliff1_w,
  output logic [15:0]        distance
);

  localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;

  state_t             state;
  logic               start_q;
  logic [9:0]         pos_x_p0;
  logic [9:0]         pos_y_p0;
  logic [15:0]        lfsr;
  logic [DIV_W-1:0]   div;
  logic [15:0]        spawn_cnt;
  logic [15:0]        spacing;

  logic               rise;
  logic               tick;
  logic               fb;
  logic               ground;
  logic               ret0;
  logic               ret1;
  logic               v0_n;
  logic               v1_n;
  logic               spawn;
  logic signed [11:0] cx;
  logic [15:0]        cnt_inc;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Right edge (exclusive) of a gap, widened so negative x stays exact.
  function automatic logic signed [11:0] gap_end(input logic signed [10:0] x, input logic [5:0] w);
    return $signed({x[10], x}) + $signed({6'b000000, w});
  endfunction

  function automatic logic over_gap(input logic valid, input logic signed [10:0] x,
                                    input logic [5:0] w, input logic signed [11:0] c);
    logic signed [11:0] xs;
    xs = $signed({x[10], x});
    return valid && (xs <= c) && (c < gap_end(x, w));
  endfunction

  always_comb begin
    rise    = start & ~start_q;
    tick    = (div == DIV_LAST);
    fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    cx      = $signed({2'b00, pos_x_p0}) + $signed(12'(MARIO_HALF));
    ground  = ~(over_gap(cliff0_valid, cliff0_x, cliff0_w, cx) |
                over_gap(cliff1_valid, cliff1_x, cliff1_w, cx));
    // A slot retires on the tick that takes its right edge to zero or below.
    ret0    = cliff0_valid && (gap_end(cliff0_x, cliff0_w) <= 12'sd1);
    ret1    = cliff1_valid && (gap_end(cliff1_x, cliff1_w) <= 12'sd1);
    v0_n    = cliff0_valid & ~ret0;
    v1_n    = cliff1_valid & ~ret1;
    cnt_inc = sat_inc16(spawn_cnt);
    spawn   = (cnt_inc >= spacing) && !(v0_n && v1_n);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      start_q         <= 1'b0;
      pos_x_p0        <= '0;
      pos_y_p0        <= '0;
      lfsr            <= LFSR_SEED;
      div             <= '0;
      spawn_cnt       <= '0;
      spacing         <= 16'(SPACE_MIN);
      mario_on_ground <= 1'b1;
      game_over       <= 1'b0;
      running         <= 1'b0;
      cliff0_valid    <= 1'b0;
      cliff1_valid    <= 1'b0;
      cliff0_x        <= '0;
      cliff1_x        <= '0;
      cliff0_w        <= '0;
      cliff1_w        <= '0;
      distance        <= '0;
    end else begin
      lfsr            <= {lfsr[14:0], fb};
      start_q         <= start;
      pos_x_p0        <= pos_x;
      pos_y_p0        <= pos_y;
      mario_on_ground <= (state == IDLE) ? 1'b1 : ground;

      if (state != RUN && rise) begin
        state        <= RUN;
        running      <= 1'b1;
        game_over    <= 1'b0;
        cliff0_valid <= 1'b0;
        cliff1_valid <= 1'b0;
        cliff0_x     <= '0;
        cliff1_x     <= '0;
        cliff0_w     <= '0;
        cliff1_w     <= '0;
        distance     <= '0;
        spawn_cnt    <= '0;
        div          <= '0;
        spacing      <= 16'(SPACE_MIN);
      end else if (state == RUN) begin
        if (pos_y_p0 >= 10'(FLOOR_Y)) begin
          state     <= OVER;
          game_over <= 1'b1;
          running   <= 1'b0;
        end
        if (tick) begin
          div          <= '0;
          distance     <= sat_inc16(distance);
          cliff0_valid <= v0_n;
          cliff1_valid <= v1_n;
          if (cliff0_valid) cliff0_x <= cliff0_x - 11'sd1;
          if (cliff1_valid) cliff1_x <= cliff1_x - 11'sd1;
          // Spawn fills the lowest free slot, including one freed on this same tick.
          if (spawn) begin
            spawn_cnt <= '0;
            spacing   <= 16'(SPACE_MIN) + {8'h00, lfsr[12:5]};
            if (!v0_n) begin
              cliff0_valid <= 1'b1;
              cliff0_x     <= 11'(SPAWN_X);
              cliff0_w     <= 6'(W_MIN) + {1'b0, lfsr[4:0]};
            end else begin
              cliff1_valid <= 1'b1;
              cliff1_x     <= 11'(SPAWN_X);
              cliff1_w     <= 6'(W_MIN) + {1'b0, lfsr[4:0]};
            end
          end else begin
            spawn_cnt <= cnt_inc;
          end
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cliff_track.sv
// Bench for cliff_track: directed phases with free-running LFSR-driven cliffs, checked
// every cycle against a behavioural model of the track rules.
module tb_cliff_track;

  localparam int DIV   = 4;
  localparam int SMIN  = 2;
  localparam int WMIN  = 24;
  localparam int HALF  = 16;
  localparam int FLOOR = 480;
  localparam int SPX   = 640;
  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_OVER = 2;
  localparam logic [54:0] RESET_VEC = 55'd1 << 52;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [9:0]         pos_x = '0;
  logic [9:0]         pos_y = '0;
  logic               mario_on_ground;
  logic               game_over;
  logic               running;
  logic               cliff0_valid;
  logic               cliff1_valid;
  logic signed [10:0] cliff0_x;
  logic signed [10:0] cliff1_x;
  logic [5:0]         cliff0_w;
  logic [5:0]         cliff1_w;
  logic [15:0]        distance;

  always #5 clk = ~clk;

  cliff_track #(.SCROLL_DIV(DIV), .SPACE_MIN(SMIN)) dut (
    .clk(clk), .reset(reset), .start(start), .pos_x(pos_x), .pos_y(pos_y),
    .mario_on_ground(mario_on_ground), .game_over(game_over), .running(running),
    .cliff0_valid(cliff0_valid), .cliff1_valid(cliff1_valid),
    .cliff0_x(cliff0_x), .cliff1_x(cliff1_x), .cliff0_w(cliff0_w), .cliff1_w(cliff1_w),
    .distance(distance)
  );

  wire [54:0] dut_vec = {running, game_over, mario_on_ground,
                         cliff0_valid, cliff0_x, cliff0_w,
                         cliff1_valid, cliff1_x, cliff1_w, distance};

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int         m_st;
  bit         m_sq;
  int         m_px, m_py;
  bit [15:0]  m_lfsr;
  int         m_div, m_cnt, m_space, m_dist;
  bit         m_v[2];
  int         m_x[2], m_w[2];
  bit         m_mog, m_go;
  bit         refill_seen = 1'b0;
  bit         waited = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ground_fn(input int c);
    bit over;
    over = 1'b0;
    for (int i = 0; i < 2; i++)
      if (m_v[i] && m_x[i] <= c && c < m_x[i] + m_w[i]) over = 1'b1;
    return !over;
  endfunction

  function automatic logic [54:0] model_vec();
    return {m_st == ST_RUN, m_go, m_mog,
            m_v[0], 11'(m_x[0]), 6'(m_w[0]),
            m_v[1], 11'(m_x[1]), 6'(m_w[1]), 16'(m_dist)};
  endfunction

  task automatic clear_run();
    m_go = 1'b0;
    for (int i = 0; i < 2; i++) begin m_v[i] = 1'b0; m_x[i] = 0; m_w[i] = 0; end
    m_dist = 0; m_cnt = 0; m_div = 0; m_space = SMIN;
  endtask

  task automatic model_reset();
    clear_run();
    m_st = ST_IDLE; m_mog = 1'b1; m_lfsr = 16'hACE1;
    m_sq = 1'b0; m_px = 0; m_py = 0;
  endtask

  task automatic model_edge();
    bit [15:0] l;
    bit rise, g, ret0;
    int ci, s;
    l = m_lfsr;
    rise = start && !m_sq;
    g = ground_fn(m_px + HALF);
    if (m_st == ST_IDLE) begin
      m_mog = 1'b1;
      if (rise) begin clear_run(); m_st = ST_RUN; end
    end else if (m_st == ST_OVER) begin
      m_mog = g;
      if (rise) begin clear_run(); m_st = ST_RUN; end
    end else begin
      m_mog = g;
      if (m_py >= FLOOR) begin m_st = ST_OVER; m_go = 1'b1; end
      if (m_div == DIV - 1) begin
        m_div = 0;
        ret0 = 1'b0;
        for (int i = 0; i < 2; i++)
          if (m_v[i]) begin
            if (m_x[i] + m_w[i] <= 1) begin m_v[i] = 1'b0; if (i == 0) ret0 = 1'b1; end
            m_x[i] = m_x[i] - 1;
          end
        m_dist = (m_dist < 65535) ? m_dist + 1 : 65535;
        ci = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        if (ci >= m_space && (!m_v[0] || !m_v[1])) begin
          s = m_v[0] ? 1 : 0;
          if (s == 0 && ret0 && waited) refill_seen = 1'b1;
          m_v[s] = 1'b1; m_x[s] = SPX; m_w[s] = WMIN + int'(l[4:0]);
          m_cnt = 0; m_space = SMIN + int'(l[12:5]);
        end else begin
          if (ci >= m_space) waited = 1'b1;
          m_cnt = ci;
        end
      end else begin
        m_div = m_div + 1;
      end
    end
    m_sq = start; m_px = int'(pos_x); m_py = int'(pos_y);
    m_lfsr = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_reset(); else model_edge();
    @(negedge clk);
    chk("outputs", {9'b0, dut_vec}, {9'b0, model_vec()});
  endtask

  initial begin
    int n, a, b, px, snap_d, snap_x;
    bit exp_g;

    // Asynchronous reset before any clock edge
    #2 reset = 1'b0;
    #1 chk("reset_values", {9'b0, dut_vec}, {9'b0, RESET_VEC});
    model_reset();
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Start and first spawn on the second tick
    start = 1'b1;
    step();
    start = 1'b0;
    chk("running_after_start", {63'b0, running}, 64'd1);
    n = 0;
    while (!m_v[0] && n < 20) begin step(); n++; end
    chk("first_spawn_latency", n, 8);
    chk("spawn_x", {53'b0, $unsigned(cliff0_x)}, 64'd640);
    chk("spawn_w", {58'b0, cliff0_w}, m_w[0]);
    chk("distance_after_spawn", {48'b0, distance}, 64'd2);

    // Scroll slot0 into view, then sweep Mario's centre across its edges
    n = 0;
    while (!(m_v[0] && m_x[0] <= 200) && n < 3000) begin step(); n++; end
    chk("scroll_reached", {63'b0, m_v[0] && m_x[0] <= 200}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (m_div != 0 && n < 8) begin step(); n++; end
      a = m_x[0];
      b = m_x[0] + m_w[0];
      case (k)
        0: px = a - HALF - 1;
        1: px = a - HALF;
        2: px = b - HALF - 1;
        default: px = b - HALF;
      endcase
      pos_x = 10'(px);
      step(); step();
      exp_g = ground_fn(px + HALF);
      chk("gap_sweep", {63'b0, mario_on_ground}, {63'b0, exp_g});
      if (k == 1 || k == 2) chk("gap_inside", {63'b0, mario_on_ground}, 64'd0);
    end
    pos_x = '0;

    // Both slots full and waiting; slot0 retires and is refilled on one tick
    n = 0;
    while (!refill_seen && n < 4000) begin step(); n++; end
    chk("refill_seen", {63'b0, refill_seen}, 64'd1);
    chk("waited_before_refill", {63'b0, waited}, 64'd1);
    chk("refill_x", {53'b0, $unsigned(cliff0_x)}, 64'd640);
    chk("refill_v0", {63'b0, cliff0_valid}, 64'd1);
    chk("refill_v1", {63'b0, cliff1_valid}, 64'd1);

    // Fall ends the run and freezes the track
    pos_y = 10'(FLOOR);
    step();
    chk("fall_go_early", {63'b0, game_over}, 64'd0);
    step();
    chk("fall_game_over", {63'b0, game_over}, 64'd1);
    chk("fall_not_running", {63'b0, running}, 64'd0);
    snap_d = m_dist;
    snap_x = m_x[0];
    for (int i = 0; i < 12; i++) step();
    chk("frozen_distance", {48'b0, distance}, snap_d);
    chk("frozen_x", {53'b0, $unsigned(cliff0_x)}, {53'b0, 11'(snap_x)});

    // Restart from OVER
    pos_y = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_go", {63'b0, game_over}, 64'd0);
    chk("restart_running", {63'b0, running}, 64'd1);
    chk("restart_distance", {48'b0, distance}, 64'd0);
    chk("restart_slots", {62'b0, cliff0_valid, cliff1_valid}, 64'd0);
    for (int i = 0; i < 6; i++) step();

    // Distance saturation
    force dut.distance = 16'hFFFD;
    #1 release dut.distance;
    m_dist = 65533;
    for (int i = 0; i < 13; i++) step();
    chk("dist_saturate", {48'b0, distance}, 64'hFFFF);

    // Asynchronous reset mid-run, between clock edges
    reset = 1'b0;
    #1 chk("async_reset_midrun", {9'b0, dut_vec}, {9'b0, RESET_VEC});
    model_reset();
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
